// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the raw line pair, deserialises 11-bit frames and folds
// E0/F0/E1 prefix bytes into single key events on the 11-bit ps2_key word.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 56000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StPrefix, StSkip} state_e;

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          filt_q;
  logic [7:0]    flt_cnt_q;
  logic          fall;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, frame_err_q;

  state_e        state_q, state_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;
  logic          is_discard, is_fake_shift;

  // Synchronisers and clock glitch filter; the filtered clock only moves after FILTER_LEN
  // consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      if (clk_sync_q != filt_q) begin
        if (flt_cnt_q == 8'(FILTER_LEN - 1)) begin
          filt_q    <= clk_sync_q;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + 8'd1;
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  assign fall = filt_q && !clk_sync_q && (flt_cnt_q == 8'(FILTER_LEN - 1));

  // Frame deserialiser with idle timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      timer_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        timer_q <= '0;
        if (bit_cnt_q == 4'd0) begin
          if (!dat_sync_q) bit_cnt_q <= 4'd1;
        end else if (bit_cnt_q <= 4'd8) begin
          shift_q   <= {dat_sync_q, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end else if (bit_cnt_q == 4'd9) begin
          par_q     <= dat_sync_q;
          bit_cnt_q <= 4'd10;
        end else begin
          bit_cnt_q <= '0;
          if (dat_sync_q && ^{par_q, shift_q}) begin
            rx_data_q  <= shift_q;
            rx_valid_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (timer_q == TW'(TIMEOUT - 1)) begin
          timer_q     <= '0;
          bit_cnt_q   <= '0;
          frame_err_q <= 1'b1;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  // Byte-level prefix folding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      skip_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      skip_q  <= skip_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    case (rx_data_q)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                                 is_discard = 1'b0;
    endcase
    is_fake_shift = ext_q && (rx_data_q == 8'h12 || rx_data_q == 8'h59);
  end

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    skip_d  = skip_q;
    key_d   = key_q;
    if (rx_valid_q) begin
      case (state_q)
        StSkip: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = StIdle;
        end
        default: begin
          if (rx_data_q == 8'hE0) begin
            ext_d   = 1'b1;
            state_d = StPrefix;
          end else if (rx_data_q == 8'hF0) begin
            rel_d   = 1'b1;
            state_d = StPrefix;
          end else if (rx_data_q == 8'hE1) begin
            ext_d   = 1'b0;
            rel_d   = 1'b0;
            skip_d  = 3'd7;
            state_d = StSkip;
          end else begin
            ext_d   = 1'b0;
            rel_d   = 1'b0;
            state_d = StIdle;
            if (!is_discard && !is_fake_shift) key_d = {~key_q[10], ~rel_q, ext_q, rx_data_q};
          end
        end
      endcase
    end
  end

  assign ps2_key   = key_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
